keypad_arbiter: RTL and testbench

KEYPAD_ARBITER -- requirements
Module: keypad_arbiter

---
 rtl/keypad_arbiter.sv | 103 ++++++++++
 tb/tb_keypad_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_arbiter.sv
// keypad_arbiter: round-robin arbiter that feeds one requester's 4-digit code to a shared combination lock
// Ports: clk/rst (sync, active-high); req/code per requester (code i on bits [16i+15:16i], digit 0 in top nibble);
//        ack/done one-cycle per-requester pulses; res_* result flags valid only with done; busy = not IDLE;
//        lk_enter/lk_pass drive the lock; lk_grant/lk_deny/lk_lock are the lock's outputs.
module keypad_arbiter #(
    parameter int N_REQ        = 4,
    parameter int RESP_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [16*N_REQ-1:0]   code,
    output logic [N_REQ-1:0]      ack,
    output logic [N_REQ-1:0]      done,
    output logic                  res_grant,
    output logic                  res_deny,
    output logic                  res_locked,
    output logic                  res_timeout,
    output logic                  busy,
    output logic                  lk_enter,
    output logic [3:0]            lk_pass,
    input  logic                  lk_grant,
    input  logic                  lk_deny,
    input  logic                  lk_lock
);
    localparam int W  = $clog2(N_REQ);
    localparam int TW = $clog2(RESP_TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, ENTER, DIGIT, WAIT_RESP, DONE} state_t;
    state_t          state, state_n;
    logic [W-1:0]    rr_ptr, win, sel;
    logic [W:0]      idx;
    logic [1:0]      dcnt, dcnt_n;
    logic [TW-1:0]   tcnt;
    logic [15:0]     code_q;
    logic [3:0]      res_n;
    logic            take;
    // Walk offsets from the far end down so the requester closest to rr_ptr is the last (winning) hit.
    always_comb begin
        sel = '0;
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = {1'b0, rr_ptr} + (W+1)'(i);
            if (idx >= (W+1)'(N_REQ)) idx = idx - (W+1)'(N_REQ);
            if (req[idx[W-1:0]]) sel = idx[W-1:0];
        end
    end
    always_comb begin
        state_n = state;
        res_n   = 4'b0000;
        case (state)
            IDLE:      if (|req && !lk_lock) state_n = ENTER;
            ENTER:     state_n = DIGIT;
            DIGIT:     if (dcnt == 2'd3) state_n = WAIT_RESP;
            WAIT_RESP: begin
                // A response on the last counted cycle still beats the timeout.
                if (lk_lock || lk_deny || lk_grant) begin
                    state_n = DONE;
                    res_n   = lk_lock ? 4'b1000 : lk_deny ? 4'b0100 : 4'b0010;
                end else if (tcnt == TW'(RESP_TIMEOUT - 1)) begin
                    state_n = DONE;
                    res_n   = 4'b0001;
                end
            end
            DONE:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end
    assign dcnt_n = (state == DIGIT) ? dcnt + 2'd1 : 2'd0;
    assign take   = (state == IDLE) && (state_n == ENTER);
    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            win      <= '0;
            code_q   <= '0;
            dcnt     <= '0;
            tcnt     <= '0;
            ack      <= '0;
            done     <= '0;
            {res_locked, res_deny, res_grant, res_timeout} <= 4'b0000;
            busy     <= 1'b0;
            lk_enter <= 1'b0;
            lk_pass  <= 4'd0;
        end else begin
            state <= state_n;
            dcnt  <= dcnt_n;
            tcnt  <= (state == WAIT_RESP) ? tcnt + 1'b1 : '0;
            if (take) begin
                win    <= sel;
                code_q <= code[{sel, 4'b0000} +: 16];
                rr_ptr <= (sel == W'(N_REQ - 1)) ? '0 : sel + 1'b1;
            end
            ack      <= take ? N_REQ'(1) << sel : '0;
            done     <= (state_n == DONE) ? N_REQ'(1) << win : '0;
            {res_locked, res_deny, res_grant, res_timeout} <= res_n;
            busy     <= state_n != IDLE;
            lk_enter <= state_n == ENTER;
            // Digit k sits at nibble 3-k, i.e. nibble ~k for a 2-bit k.
            lk_pass  <= (state_n == DIGIT) ? code_q[{~dcnt_n, 2'b00} +: 4] : 4'd0;
        end
    end
endmodule

// File: tb/tb_keypad_arbiter.sv
// tb_keypad_arbiter: scoreboard bench for keypad_arbiter with directed sessions
module tb_keypad_arbiter;
    localparam int N = 4;
    localparam int T = 16;
    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] req, ack, done;
    logic [16*N-1:0] code;
    logic res_grant, res_deny, res_locked, res_timeout, busy, lk_enter;
    logic [3:0] lk_pass;
    logic lk_grant, lk_deny, lk_lock;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    typedef struct {
        bit          is_done;
        int          idx;
        logic [3:0]  flags;
        logic [15:0] cd;
        int          at;
    } ev_t;
    ev_t q[$];

    keypad_arbiter #(.N_REQ(N), .RESP_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .req(req), .code(code), .ack(ack), .done(done),
        .res_grant(res_grant), .res_deny(res_deny), .res_locked(res_locked), .res_timeout(res_timeout),
        .busy(busy), .lk_enter(lk_enter), .lk_pass(lk_pass),
        .lk_grant(lk_grant), .lk_deny(lk_deny), .lk_lock(lk_lock)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic wait_until(int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(bit d, int i, logic [3:0] f, logic [15:0] c, int at);
        ev_t e;
        e.is_done = d;
        e.idx     = i;
        e.flags   = f;
        e.cd      = c;
        e.at      = at;
        q.push_back(e);
    endtask

    task automatic start(int idx, output int a);
        req[idx] = 1'b1;
        a = cyc + 1;
        push(1'b0, idx, 4'b0000, code[idx*16 +: 16], a);
    endtask

    // drv = {lock,deny,grant}, applied d cycles into WAIT_RESP; drv==0 means let it time out.
    task automatic finish(int idx, int d, logic [2:0] drv, logic [3:0] ex, int a);
        int dc;
        wait_until(a + 1);
        req[idx] = 1'b0;
        dc = (drv == 3'b000) ? a + 5 + T : a + 6 + d;
        wait_until((drv == 3'b000) ? a + 5 : a + 5 + d);
        {lk_lock, lk_deny, lk_grant} = drv;
        push(1'b1, idx, ex, 16'h0, dc);
        wait_until(dc);
        {lk_lock, lk_deny, lk_grant} = 3'b000;
        wait_until(dc + 1);
    endtask

    initial begin
        int dl;
        logic [15:0] dc;
        ev_t e;
        dl = 0;
        dc = '0;
        forever begin
            @(negedge clk);
            if (dl > 0) begin
                chk("digit", 32'(lk_pass), 32'(dc[15:12]));
                dc = dc << 4;
                dl--;
            end
            if (rst) dl = 0;
            if (ack != 0 || done != 0) begin
                if (q.size() == 0) chk("unexpected_event", 32'({ack, done}), 32'd0);
                else begin
                    e = q.pop_front();
                    chk(e.is_done ? "done_vec" : "ack_vec", 32'(e.is_done ? done : ack), 32'(N'(1) << e.idx));
                    chk("event_cycle", 32'(cyc), 32'(e.at));
                    if (e.is_done) chk("flags", 32'({res_locked, res_deny, res_grant, res_timeout}), 32'(e.flags));
                    else begin
                        chk("enter", 32'(lk_enter), 32'd1);
                        chk("enter_pass", 32'(lk_pass), 32'd0);
                        dl = 4;
                        dc = e.cd;
                    end
                end
            end else chk("idle_flags", 32'({res_locked, res_deny, res_grant, res_timeout}), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int a, c;
        rst = 1'b1;
        req = '0;
        code = {16'h0f0f, 16'h9abc, 16'h1537, 16'h2468};
        {lk_lock, lk_deny, lk_grant} = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", 32'({ack, done, busy, lk_enter, lk_pass, res_grant, res_deny, res_locked, res_timeout}), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        // Round robin with all requests held: 0,1,2,3,0, 8 cycles apart.
        c = cyc;
        req = 4'hf;
        for (int j = 0; j < 5; j++) begin
            a = c + 1 + 8 * j;
            push(1'b0, j % 4, 4'b0000, code[(j % 4) * 16 +: 16], a);
            wait_until(a + 5);
            lk_grant = 1'b1;
            if (j == 4) req = '0;
            push(1'b1, j % 4, 4'b0010, 16'h0, a + 6);
            wait_until(a + 6);
            lk_grant = 1'b0;
        end
        wait_until(c + 33 + 7);
        // Reset mid-DIGIT: requester 1 wins (rr_ptr=1), reset during digit 2, then 0 wins from rr_ptr=0.
        c = cyc;
        req = 4'b1011;
        a = c + 1;
        push(1'b0, 1, 4'b0000, code[16 +: 16], a);
        wait_until(a + 3);
        rst = 1'b1;
        wait_until(a + 4);
        rst = 1'b0;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_pass", 32'(lk_pass), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        push(1'b0, 0, 4'b0000, code[0 +: 16], a + 5);
        wait_until(a + 5);
        req = '0;
        finish(0, 0, 3'b001, 4'b0010, a + 5);
        // Requester 1, code 1537, granted on first WAIT_RESP cycle.
        start(1, a);
        finish(1, 0, 3'b001, 4'b0010, a);
        // Lock held in IDLE blocks requester 2 until it drops.
        c = cyc;
        lk_lock = 1'b1;
        req[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("locked_ack", 32'(ack), 32'd0);
            chk("locked_busy", 32'(busy), 32'd0);
        end
        lk_lock = 1'b0;
        push(1'b0, 2, 4'b0000, code[32 +: 16], c + 4);
        finish(2, 0, 3'b010, 4'b0100, c + 4);
        // Lock and deny together: locked wins.
        start(3, a);
        finish(3, 0, 3'b110, 4'b1000, a);
        // No response: timeout T cycles after entering WAIT_RESP.
        start(0, a);
        finish(0, 0, 3'b000, 4'b0001, a);
        // Response on the last counted cycle beats the timeout.
        start(1, a);
        finish(1, T - 1, 3'b001, 4'b0010, a);
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
